// File: rtl/tt_stream_fifo.sv
// ============================================================================
// tt_stream_fifo
// ----------------------------------------------------------------------------
// Parametrised valid/ready stream FIFO that sits behind the tile pin wrapper
// and turns the direct input-to-output passthrough into a registered,
// flow-controlled path. Fill level and an error flag are exposed for debug.
//
// Parameters:
//   WIDTH      data width in bits (1..32)
//   DEPTH      entry count, power of two (2..256)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   ena        block enable; when low no push or pop is accepted
//   in_data    write data
//   in_valid   producer has data
//   in_ready   FIFO can accept a word (!full && ena)
//   out_data   head-of-queue data, first-word-fall-through
//   out_valid  head is valid (!empty && ena)
//   out_ready  consumer takes the head
//   level      current occupancy, 0..DEPTH
//   err        sticky overflow/underflow attempt flag
//
// Build option:
//   STREAM_FIFO_ERR_EN  when defined, err is a sticky register set by a push
//                       attempt while full or a pop attempt while empty and
//                       cleared only by rst. When undefined, err is tied to 0
//                       and the error logic is not compiled.
// ============================================================================
module tt_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Storage array; deliberately has no reset so it can map onto plain
    // register files or distributed RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_inc;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] head_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic level_is_one;

    // Status is derived purely from the registered level, so in_ready never
    // combinationally depends on out_ready. A push while full is therefore
    // refused even if a pop happens in the same cycle.
    assign full         = (level_q == LEVEL_FULL);
    assign empty        = (level_q == '0);
    assign level_is_one = (level_q == LEVEL_ONE);

    assign in_ready  = !full && ena;
    assign out_valid = !empty && ena;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign rd_ptr_inc = rd_ptr + PTR_ONE;

    assign level    = level_q;
    assign out_data = head_q;

    // Write port. A push presented during the reset cycle is ignored.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // Level tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Registered head-of-queue. Keeping the head in its own register lets
    // out_data hold the last popped word once the FIFO drains, instead of
    // showing whatever stale entry the read pointer now addresses.
    //  - A push lands straight in the head when the queue is empty, or when
    //    the only stored word is popped in the same cycle.
    //  - A pop with two or more words stored fetches the next entry, which
    //    is already in storage from an earlier edge.
    //  - A pop of the last word with no push keeps the popped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
        end else if (push && (empty || (level_is_one && pop))) begin
            head_q <= in_data;
        end else if (pop && !level_is_one) begin
            head_q <= mem[rd_ptr_inc];
        end
    end

`ifdef STREAM_FIFO_ERR_EN
    logic err_q;

    // Sticky error: an enabled push attempt while full, or an enabled pop
    // attempt while empty. Only reset clears it; refused transfers never
    // touch FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((in_valid && ena && full) || (out_ready && ena && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_stream_fifo.sv
// ============================================================================
// tb_tt_stream_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for tt_stream_fifo (WIDTH=8, DEPTH=16). A queue-based
// reference model holds the expected FIFO contents; a monitor compares the
// DUT outputs against it on every falling edge. Directed sequences cover the
// main scenarios, followed by a randomized phase with occasional resets.
// ============================================================================
module tb_tt_stream_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic             ena;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [$clog2(DEPTH):0] level;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] last_out = '0;
    bit               exp_err  = 1'b0;
    bit               started  = 1'b0;
    bit               m_push;
    bit               m_pop;

    tt_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; they change just after a rising edge so the
    // model and the DUT both see stable values at the next edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic r, input logic e, input logic rs);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        ena       = e;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO is simply an ordered queue of accepted words.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            exp_err  = 1'b0;
            last_out = '0;
            started  = 1'b1;
        end else if (started) begin
            m_push = in_valid && ena && (sb.size() < DEPTH);
            m_pop  = out_ready && ena && (sb.size() > 0);
`ifdef STREAM_FIFO_ERR_EN
            if (in_valid && ena && (sb.size() == DEPTH)) exp_err = 1'b1;
            if (out_ready && ena && (sb.size() == 0))    exp_err = 1'b1;
`endif
            if (m_pop)  last_out = sb.pop_front();
            if (m_push) sb.push_back(in_data);
        end
    end

    // Monitor: compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("level", 32'(level), 32'(sb.size()));
            checkOutput("in_ready", 32'(in_ready), 32'((sb.size() < DEPTH) && ena));
            checkOutput("out_valid", 32'(out_valid), 32'((sb.size() > 0) && ena));
            checkOutput("err", 32'(err), 32'(exp_err));
            if (sb.size() > 0) begin
                if (ena) checkOutput("out_data", 32'(out_data), 32'(sb[0]));
            end else begin
                checkOutput("out_data_hold", 32'(out_data), 32'(last_out));
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ena       = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Three back-to-back pushes, then three pops.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill to full, attempt an overflow push, then drain.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Sustained stream across pointer wrap.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Pop attempts while empty.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Level 5, then enable dropped for four cycles, then resume.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Level 7, reset alongside a push, then a fresh push of 0x5C.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Randomized traffic; consumer bias flips halfway to reach both
        // full and empty regularly.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          8'($urandom),
                          (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 149) == 0));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_stream_fifo.md
# tt_stream_fifo

Parametrised valid/ready stream FIFO that buffers data between the dedicated input pins and the dedicated output pins of a tile design. It replaces the direct pin-to-pin passthrough with a registered, flow-controlled path of configurable width and depth. The block exposes fill level and an error flag for debug pins. It sits directly behind the top-level pin wrapper.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits, 1..32.
- `DEPTH`, 16: entry count; power of two, 2..256.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  block enable; when 0, no push or pop is accepted.
- `in_data`  in  WIDTH  write data.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO can accept; `!full && ena`.
- `out_data`  out  WIDTH  head-of-queue data, first-word-fall-through.
- `out_valid`  out  1  `!empty && ena`.
- `out_ready`  in  1  consumer takes head.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `err`  out  1  error flag (see Configuration).

## Operation
- Push: `in_valid && in_ready` on a rising edge writes `in_data` at the write pointer; the write pointer increments.
- Pop: `out_valid && out_ready` on a rising edge advances the read pointer.
- Pointers are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0 with no special handling.
- `level`: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- Full: `level == DEPTH`. Empty: `level == 0`.
- `in_ready` depends only on registered state and `ena`, never on `out_ready`. A push when full is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop with level 1..DEPTH-1: both complete; the popped word is the old head.
- When empty, `out_data` holds the last popped value (or 0 after reset). Its value is don't-care while `out_valid` is 0.
- `ena` low: `in_ready` and `out_valid` read 0; storage, pointers and `level` are held.
- Storage array is not reset; only pointers, `level` and `err` are reset.

## Timing
- Reset (`rst` high at an edge): `level` 0, pointers 0, `err` 0, `out_valid` 0, `in_ready` = `ena`, `out_data` 0.
- Reset mid-operation discards all queued entries. Any push or pop presented in the reset cycle is ignored.
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid` 1 after edge N, so it is poppable at edge N+1.
- `in_ready` rises one cycle after the pop that leaves the FIFO non-full.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `STREAM_FIFO_ERR_EN` defined:
  - `err` is a sticky register.
  - Set on any edge with `in_valid && !in_ready && ena` while full (overflow attempt).
  - Set on any edge with `out_ready && !out_valid && ena` (underflow attempt).
  - Cleared only by `rst`.
- Macro not defined: `err` is tied to 0 and the error logic is not compiled.
- Refused pushes and pops never alter FIFO state in either build.

## Test plan
- Reset, then push 0x11,0x22,0x33 back-to-back with `out_ready` 0 -> `level` 3, `out_data` 0x11, `out_valid` 1. Pop three -> 0x11,0x22,0x33 in order, `level` 0.
- Fill DEPTH=16 with 0x00..0x0F -> `in_ready` 0 at `level` 16. Hold `in_valid` with 0xAA for 1 cycle -> no write; with ERR_EN, `err` 1. Pop all -> 0x00..0x0F.
- Steady stream: `in_valid` and `out_ready` held 1 for 40 cycles with incrementing data -> `level` stays 1 after the first cycle and output sequence matches input. Covers pointer wrap at 16.
- Empty FIFO with `out_ready` 1 -> `out_valid` 0, `level` stays 0. `err` 1 with ERR_EN, 0 without.
- `level` 5, drop `ena` for 4 cycles with `in_valid`/`out_ready` 1 -> `level` stays 5. Raise `ena` -> transfers resume with the correct head.
- `level` 7, assert `rst` for one cycle alongside a push -> `level` 0, `out_valid` 0, `err` 0. The next push of 0x5C appears at `out_data` one cycle later.
